// File: rtl/ha_mul_pkg.sv
// rtl/ha_mul_pkg.sv - shared constants, state type and row weight helpers for the ha_array multiplier front end
package ha_mul_pkg;

    localparam int OP_W     = 8;
    localparam int NUM_ROWS = OP_W / 2;
    localparam int T_W      = 9;
    localparam int B_W      = 7;
    localparam int PROD_W   = 2 * OP_W;
    localparam int CNT_W    = $clog2(NUM_ROWS);
    localparam int SHIFT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Row r starts at weight 2r because each row consumes two multiplier bits.
    function automatic logic [SHIFT_W-1:0] row_t_weight_shift(input logic [CNT_W-1:0] r);
        return SHIFT_W'({r, 1'b0});
    endfunction

    // Carry outputs of row r sit two columns above its sum outputs.
    function automatic logic [SHIFT_W-1:0] row_b_weight_shift(input logic [CNT_W-1:0] r);
        return SHIFT_W'({r, 1'b0}) + SHIFT_W'(2);
    endfunction

endpackage

// File: rtl/ha_array_row_sequencer_if.sv
// rtl/ha_array_row_sequencer_if.sv - operand, product and ha_array signal bundle for the row sequencer
interface ha_array_row_sequencer_if;
    import ha_mul_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [OP_W-1:0]          in_x;
    logic [OP_W-1:0]          in_y;
    logic [OP_W-1:0]          ha_x;
    logic [OP_W-1:0]          ha_y;
    logic [NUM_ROWS*T_W-1:0]  ha_t;
    logic [NUM_ROWS*B_W-1:0]  ha_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [PROD_W-1:0]        out_prod;

    // Sequencer side.
    modport master (
        input  in_valid,
        output in_ready,
        input  in_x,
        input  in_y,
        output ha_x,
        output ha_y,
        input  ha_t,
        input  ha_b,
        output out_valid,
        input  out_ready,
        output out_prod
    );

    // Operand source, product consumer and ha_array side.
    modport slave (
        output in_valid,
        input  in_ready,
        output in_x,
        output in_y,
        input  ha_x,
        input  ha_y,
        output ha_t,
        output ha_b,
        input  out_valid,
        output out_ready,
        input  out_prod
    );

endinterface

// File: rtl/ha_row_align.sv
// rtl/ha_row_align.sv - selects one ha_array row pair and aligns it to product weight
module ha_row_align
    import ha_mul_pkg::*;
(
    input  logic [NUM_ROWS*T_W-1:0] ha_t,
    input  logic [NUM_ROWS*B_W-1:0] ha_b,
    input  logic [CNT_W-1:0]        row,
    output logic [PROD_W-1:0]       addend
);

    logic [T_W-1:0] t_r;
    logic [B_W-1:0] b_r;

    // Row mux built from constant slices so every select is a static part-select.
    always_comb begin
        t_r = '0;
        b_r = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row == CNT_W'(r)) begin
                t_r = ha_t[r*T_W +: T_W];
                b_r = ha_b[r*B_W +: B_W];
            end
        end
    end

    // Zero-extend to product width, shift to the row weight, truncate to PROD_W.
    always_comb begin
        addend = (PROD_W'(t_r) << row_t_weight_shift(row))
               + (PROD_W'(b_r) << row_b_weight_shift(row));
    end

endmodule

// File: rtl/ha_array_row_sequencer.sv
// rtl/ha_array_row_sequencer.sv - latches an operand pair and reduces four ha_array rows into a product
module ha_array_row_sequencer
    import ha_mul_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    output logic                         busy,
    ha_array_row_sequencer_if.master     bus
);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

    seq_state_t          state_q;
    seq_state_t          state_d;
    logic [CNT_W-1:0]    row_cnt_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   acc_next;
    logic [PROD_W-1:0]   addend;
    logic [OP_W-1:0]     ha_x_q;
    logic [OP_W-1:0]     ha_y_q;
    logic                out_valid_q;
    logic [PROD_W-1:0]   out_prod_q;

    logic                accept;
    logic                acc_step;
    logic                last_row;
    logic                clr_cnt;
    logic                release_prod;

    ha_row_align u_row_align (
        .ha_t   (bus.ha_t),
        .ha_b   (bus.ha_b),
        .row    (row_cnt_q),
        .addend (addend)
    );

    assign acc_next = acc_q + addend;

    // Next-state and step controls; flush overrides every transition.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        acc_step     = 1'b0;
        last_row     = 1'b0;
        clr_cnt      = 1'b0;
        release_prod = 1'b0;
        if (flush) begin
            state_d = IDLE;
            clr_cnt = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    acc_step = 1'b1;
                    if (row_cnt_q == LAST_ROW) begin
                        last_row = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        release_prod = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, row counter and accumulator; acc and operands survive a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ha_x_q    <= '0;
            ha_y_q    <= '0;
            acc_q     <= '0;
            row_cnt_q <= '0;
        end else if (accept) begin
            ha_x_q    <= bus.in_x;
            ha_y_q    <= bus.in_y;
            acc_q     <= '0;
            row_cnt_q <= '0;
        end else if (acc_step) begin
            acc_q     <= acc_next;
            row_cnt_q <= row_cnt_q + CNT_W'(1);
        end else if (clr_cnt) begin
            row_cnt_q <= '0;
        end
    end

    // Product register: captured with the last row so it is valid and stable for all of DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
        end else if (flush || release_prod) begin
            out_valid_q <= 1'b0;
        end else if (last_row) begin
            out_valid_q <= 1'b1;
            out_prod_q  <= acc_next;
        end
    end

    assign bus.ha_x      = ha_x_q;
    assign bus.ha_y      = ha_y_q;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_prod  = out_prod_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ha_array_row_sequencer.sv
// tb/tb_ha_array_row_sequencer.sv - self-checking bench with an ha_array model and product reference
module tb_ha_array_row_sequencer;
    import ha_mul_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;

    int checks = 0;
    int errors = 0;

    ha_array_row_sequencer_if bus ();

    ha_array_row_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One approximate ha_array row for multiplier bits y0 (weight 0) and y1 (weight 1).
    // Column 1 is an OR cell, column 2 passes its A input to the carry output, the rest are exact half adders.
    function automatic logic [T_W+B_W-1:0] ha_row(input logic [7:0] x, input logic y0, input logic y1);
        logic [7:0] p0;
        logic [7:0] p1;
        logic [T_W-1:0] t;
        logic [B_W-1:0] b;
        p0 = x & {8{y0}};
        p1 = x & {8{y1}};
        t = '0;
        b = '0;
        t[0] = p0[0];
        t[1] = p0[1] | p1[0];
        t[2] = p1[1];
        b[1] = p0[2];
        for (int j = 3; j < 8; j++) begin
            t[j]   = p0[j] ^ p1[j-1];
            b[j-1] = p0[j] & p1[j-1];
        end
        t[8] = p1[7];
        return {t, b};
    endfunction

    logic [NUM_ROWS*T_W-1:0] model_t;
    logic [NUM_ROWS*B_W-1:0] model_b;

    // External combinational ha_array driven by the registered operands.
    always_comb begin
        logic [T_W+B_W-1:0] rv;
        model_t = '0;
        model_b = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            rv = ha_row(bus.ha_x, bus.ha_y[2*r], bus.ha_y[2*r+1]);
            model_t[r*T_W +: T_W] = rv[T_W+B_W-1 -: T_W];
            model_b[r*B_W +: B_W] = rv[B_W-1:0];
        end
    end
    assign bus.ha_t = model_t;
    assign bus.ha_b = model_b;

    // Reference product: exact product plus the error each approximate cell introduces.
    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        for (int r = 0; r < 4; r++) begin
            if (x[0] && x[1] && y[2*r] && y[2*r+1]) p = p - (1 << (2*r+1));
            if (x[2] && y[2*r]) p = p + (1 << (2*r+2));
        end
        return 16'(p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        int lat;
        start_op(x, y);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_prod"}, bus.out_prod, exp);
        @(negedge clk);
        chk({tag, "_idle"}, bus.in_ready, 1);
    endtask

    initial begin
        int lat;
        logic [7:0] rx;
        logic [7:0] ry;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_prod", bus.out_prod, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ha_x", bus.ha_x, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Operand latch and ACC-state outputs.
        start_op(8'd3, 8'd3);
        chk("acc_busy", busy, 1);
        chk("acc_in_ready", bus.in_ready, 0);
        chk("acc_ha_x", bus.ha_x, 3);
        chk("acc_ha_y", bus.ha_y, 3);
        wait_done(lat);
        chk("p3x3_lat", lat, 4);
        chk("p3x3_prod", bus.out_prod, 7);
        @(negedge clk);

        directed("p4x4", 8'd4, 8'd4, 16'd32);
        directed("p2x1", 8'd2, 8'd1, 16'd2);
        directed("p0x255", 8'd0, 8'd255, 16'd0);
        directed("p255x255", 8'd255, 8'd255, ref_prod(8'd255, 8'd255));

        // Consumer back-pressure: product held stable, no new operand accepted.
        bus.out_ready = 1'b0;
        start_op(8'd3, 8'd3);
        wait_done(lat);
        chk("hold_prod0", bus.out_prod, 7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_prod", bus.out_prod, 7);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", bus.out_valid, 0);
        chk("release_in_ready", bus.in_ready, 1);

        // Flush in the ACC cycle with row_cnt=2.
        start_op(8'd7, 8'd5);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_ha_x_kept", bus.ha_x, 7);
        repeat (5) @(negedge clk);
        chk("flush_no_prod", bus.out_valid, 0);

        // Flush together with in_valid in IDLE: operand refused.
        bus.in_x     = 8'd9;
        bus.in_y     = 8'd9;
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        chk("flush_iv_busy", busy, 0);
        chk("flush_iv_ha_x", bus.ha_x, 7);
        directed("post_flush", 8'd2, 8'd1, 16'd2);

        // Asynchronous reset mid-ACC.
        start_op(8'd255, 8'd255);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_prod", bus.out_prod, 0);
        chk("arst_ha_x", bus.ha_x, 0);
        chk("arst_ha_y", bus.ha_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        directed("post_arst", 8'd4, 8'd4, 16'd32);

        // Random regression against the reference product.
        for (int n = 0; n < 10000; n++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            start_op(rx, ry);
            wait_done(lat);
            if (lat >= 20) begin
                chk("rand_timeout", lat, 4);
                break;
            end
            chk("rand_prod", bus.out_prod, ref_prod(rx, ry));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
